// File: rtl/dcache_pkg.sv
// dcache_pkg: shared encodings, FSM states and geometry helpers for the data cache.
package dcache_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
   function automatic int off_w(input int block_words);
      return $clog2(block_words) + 2;
   endfunction
   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction
   function automatic int tag_w(input int sets, input int block_words);
      return 32 - idx_w(sets) - off_w(block_words);
   endfunction
endpackage

// File: rtl/dcache_lane_align.sv
// dcache_lane_align: load extract/extend and store byte-lane merge for one 32-bit word.
module dcache_lane_align
   import dcache_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [3:0]  be;
   logic [31:0] wrep;
   always_comb begin
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      load_data = func3 == F3_B  ? {{24{b[7]}}, b} :
                  func3 == F3_H  ? {{16{h[15]}}, h} :
                  func3 == F3_BU ? {24'h0, b} :
                  func3 == F3_HU ? {16'h0, h} : word;
      be = func3 == F3_B ? 4'b0001 << lane :
           func3 == F3_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      // replicate the store data so every enabled lane picks up the right byte
      wrep = func3 == F3_B ? {4{wdata[7:0]}} : func3 == F3_H ? {2{wdata[15:0]}} : wdata;
      store_word = word;
      for (int i = 0; i < 4; i++)
         if (be[i]) store_word[8*i +: 8] = wrep[8*i +: 8];
   end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate, direct-mapped data cache with miss-handling FSM.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int SETS        = 8,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        read_en,
   input  logic                        write_en,
   input  logic [31:0]                 address,
   input  logic [31:0]                 writedata,
   input  logic [2:0]                  func3,
   output logic [31:0]                 read_data,
   output logic                        busywait,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [31-off_w(BLOCK_WORDS):0] mem_address,
   output logic [32*BLOCK_WORDS-1:0]   mem_writedata,
   input  logic [32*BLOCK_WORDS-1:0]   mem_readdata,
   input  logic                        mem_busywait
);
   localparam int OFF_W = off_w(BLOCK_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(SETS, BLOCK_WORDS);
   localparam int BW    = 32 * BLOCK_WORDS;
   localparam logic [OFF_W-1:0] WMASK = ~(OFF_W'(3));
   state_t            state, next_state;
   logic [BW-1:0]     data_arr [SETS];
   logic [TAG_W-1:0]  tag_arr [SETS];
   logic [SETS-1:0]   valid, dirty;
   logic [BW-1:0]     fetch_buf;
   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  idx;
   logic [OFF_W+2:0]  bit_off;
   logic [31:0]       word, load_data, store_word;
   logic              req, hit, store_hit;
   assign tag       = address[31 -: TAG_W];
   assign idx       = address[OFF_W +: IDX_W];
   assign bit_off   = {address[OFF_W-1:0] & WMASK, 3'b000};
   assign word      = data_arr[idx][bit_off +: 32];
   assign req       = read_en | write_en;
   assign hit       = req && valid[idx] && tag_arr[idx] == tag && state == IDLE;
   assign store_hit = hit && write_en;
   assign read_data = (!reset && hit && !write_en) ? load_data : 32'h0;
   dcache_lane_align u_align (
      .func3      (func3),
      .lane       (address[1:0]),
      .word       (word),
      .wdata      (writedata),
      .load_data  (load_data),
      .store_word (store_word)
   );
   always_comb begin
      next_state    = state;
      busywait      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      case (state)
         IDLE: if (req && !hit) begin
            busywait   = 1'b1;
            next_state = valid[idx] && dirty[idx] ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            busywait      = 1'b1;
            mem_write     = 1'b1;
            mem_address   = {tag_arr[idx], idx};
            mem_writedata = data_arr[idx];
            next_state    = mem_busywait ? WRITEBACK : ALLOCATE;
         end
         ALLOCATE: begin
            busywait    = 1'b1;
            mem_read    = 1'b1;
            mem_address = {tag, idx};
            next_state  = mem_busywait ? ALLOCATE : UPDATE;
         end
         UPDATE: begin
            busywait   = 1'b1;
            next_state = IDLE;
         end
      endcase
      // the stall must drop with reset even while the pipeline holds its request
      if (reset) busywait = 1'b0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= next_state;
         if (state == UPDATE) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (store_hit) dirty[idx] <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (state == ALLOCATE && !mem_busywait) fetch_buf <= mem_readdata;
      if (state == UPDATE) begin
         data_arr[idx] <= fetch_buf;
         tag_arr[idx]  <= tag;
      end else if (store_hit) data_arr[idx][bit_off +: 32] <= store_word;
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scenarios plus randomized traffic against a byte-memory and tag reference model.
module tb_dcache_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   logic read_en = 1'b0, write_en = 1'b0;
   logic [31:0] address = '0, writedata = '0;
   logic [2:0] func3 = 3'b010;
   logic [31:0] read_data;
   logic busywait, mem_read, mem_write, mem_busywait;
   logic [27:0] mem_address;
   logic [127:0] mem_writedata, mem_readdata = '0;
   logic read_en_w = 1'b0;
   logic [31:0] address_w = '0, read_data_w;
   logic busywait_w, mem_read_w, mem_write_w, mem_busywait_w;
   logic [26:0] mem_address_w, w_addr = '0;
   logic [255:0] mem_writedata_w, mem_readdata_w = '0;
   dcache_ctrl #(.SETS(8), .BLOCK_WORDS(4)) dut (
      .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en), .address(address),
      .writedata(writedata), .func3(func3), .read_data(read_data), .busywait(busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );
   dcache_ctrl #(.SETS(16), .BLOCK_WORDS(8)) dut_w (
      .clk(clk), .reset(reset), .read_en(read_en_w), .write_en(1'b0), .address(address_w),
      .writedata(32'h0), .func3(3'b010), .read_data(read_data_w), .busywait(busywait_w),
      .mem_read(mem_read_w), .mem_write(mem_write_w), .mem_address(mem_address_w),
      .mem_writedata(mem_writedata_w), .mem_readdata(mem_readdata_w), .mem_busywait(mem_busywait_w)
   );
   int tests = 0, fails = 0;
   int lat = 0, cnt = 0, cnt_w = 0, rd_cnt = 0, wb_cnt = 0, both_cnt = 0;
   logic [27:0] rd_addr = '0, wb_addr = '0;
   logic [127:0] wb_data = '0;
   time rd_t = 0, wb_t = 0;
   logic [31:0] bk_w [int];
   logic [31:0] ref_w [int];
   logic [24:0] mt [8];
   logic [7:0] mv = '0, md = '0;
   function automatic logic [31:0] init_word(input int wa);
      return (wa * 32'h01000193) ^ 32'hA5C30F1E;
   endfunction
   function automatic logic [31:0] mword(input int wa);
      return bk_w.exists(wa) ? bk_w[wa] : init_word(wa);
   endfunction
   function automatic logic [31:0] rget(input int wa);
      return ref_w.exists(wa) ? ref_w[wa] : init_word(wa);
   endfunction
   function automatic logic [127:0] ref_blk(input logic [27:0] ba);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[32*i +: 32] = rget(int'(ba) * 4 + i);
      return b;
   endfunction
   function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
      logic [7:0] b;
      logic [15:0] h;
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      case (f)
         3'b000: return {{24{b[7]}}, b};
         3'b001: return {{16{h[15]}}, h};
         3'b100: return {24'h0, b};
         3'b101: return {16'h0, h};
         default: return w;
      endcase
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      for (int k = 0; k < 4; k++) begin
         if (f == 3'b000 && k == int'(a[1:0])) w[8*k +: 8] = d[7:0];
         else if (f == 3'b001 && (k >> 1) == int'(a[1])) w[8*k +: 8] = d[8*(k & 1) +: 8];
         else if (f != 3'b000 && f != 3'b001) w[8*k +: 8] = d[8*k +: 8];
      end
      return w;
   endfunction
   assign mem_busywait   = (mem_read | mem_write) && cnt < lat;
   assign mem_busywait_w = mem_read_w && cnt_w < 2;
   always @(posedge clk) begin
      if (mem_read && mem_write) both_cnt++;
      if (mem_write && !mem_busywait) begin
         wb_cnt++; wb_addr = mem_address; wb_data = mem_writedata; wb_t = $time;
         for (int i = 0; i < 4; i++) bk_w[int'(mem_address) * 4 + i] = mem_writedata[32*i +: 32];
      end
      if (mem_read && !mem_busywait) begin
         rd_cnt++; rd_addr = mem_address; rd_t = $time;
      end
      if (mem_read_w) w_addr <= mem_address_w;
      cnt   <= ((mem_read | mem_write) && cnt < lat) ? cnt + 1 : 0;
      cnt_w <= (mem_read_w && cnt_w < 2) ? cnt_w + 1 : 0;
   end
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) mem_readdata[32*i +: 32] = mword(int'(mem_address) * 4 + i);
      for (int i = 0; i < 8; i++) mem_readdata_w[32*i +: 32] = init_word(int'(mem_address_w) * 8 + i);
   end
   task automatic op(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     output logic [31:0] rd, output int cyc, output logic [31:0] exp_rd, output int exp_cyc,
                     output int drd, output int dwb, output int exp_drd, output int exp_dwb);
      int idx, r0, w0;
      logic hit;
      idx = int'(a[6:4]); r0 = rd_cnt; w0 = wb_cnt;
      hit = mv[idx] && mt[idx] == a[31:7];
      exp_dwb = (!hit && mv[idx] && md[idx]) ? 1 : 0;
      exp_drd = hit ? 0 : 1;
      exp_cyc = hit ? 0 : lat + 3 + (exp_dwb != 0 ? lat + 1 : 0);
      exp_rd  = wr ? 32'h0 : ext(rget(int'(a >> 2)), a, f);
      @(negedge clk);
      read_en = !wr; write_en = wr; address = a; writedata = d; func3 = f; cyc = 0;
      #1;
      while (busywait && cyc < 200) begin
         @(negedge clk); #1; cyc++;
      end
      if (busywait) begin
         tests++; fails++;
         $display("FAIL op_timeout: addr %h busywait still %b after %0d cycles, required 0", a, busywait, cyc);
      end
      rd = read_data;
      @(negedge clk);
      read_en = 1'b0; write_en = 1'b0;
      drd = rd_cnt - r0; dwb = wb_cnt - w0;
      mv[idx] = 1'b1; mt[idx] = a[31:7];
      if (!hit) md[idx] = 1'b0;
      if (wr) begin
         md[idx] = 1'b1;
         ref_w[int'(a >> 2)] = merge(rget(int'(a >> 2)), a, d, f);
      end
   endtask
   logic [31:0] rd, erd;
   int cyc, ecyc, drd, dwb, edrd, edwb, t0;
   task automatic test_reset();
      @(negedge clk);
      tests++; if (busywait !== 1'b0) begin fails++; $display("FAIL reset_busywait: got %b want 0", busywait); end
      tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
      tests++; if (mem_address !== 28'h0) begin fails++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
      tests++; if (read_data !== 32'h0) begin fails++; $display("FAIL reset_read_data: got %h want 0", read_data); end
      reset = 1'b0;
   endtask
   task automatic test_clean_miss();
      lat = 5;
      for (int i = 0; i < 4; i++) begin
         bk_w[16 + i]  = 32'h11223344 + 32'h44444444 * i;
         ref_w[16 + i] = 32'h11223344 + 32'h44444444 * i;
      end
      op(0, 32'h40, 0, 3'b010, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'h11223344) begin fails++; $display("FAIL clean_miss_data: got %h want 11223344", rd); end
      tests++; if (cyc != 8) begin fails++; $display("FAIL clean_miss_latency: got %0d want 8", cyc); end
      tests++; if (drd != 1 || rd_addr !== 28'h4) begin fails++; $display("FAIL clean_miss_fetch: reads %0d addr %h want 1 / 4", drd, rd_addr); end
      tests++; if (dwb != 0) begin fails++; $display("FAIL clean_miss_wb: got %0d want 0", dwb); end
   endtask
   task automatic test_byte_store();
      t0 = rd_cnt + wb_cnt;
      op(1, 32'h42, 32'h000000AB, 3'b000, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (cyc != 0) begin fails++; $display("FAIL sb_stall: got %0d want 0", cyc); end
      op(0, 32'h40, 0, 3'b010, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'h11AB3344) begin fails++; $display("FAIL sb_lw: got %h want 11ab3344", rd); end
      op(0, 32'h42, 0, 3'b000, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'hFFFFFFAB) begin fails++; $display("FAIL sb_lb: got %h want ffffffab", rd); end
      op(0, 32'h42, 0, 3'b100, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'h000000AB) begin fails++; $display("FAIL sb_lbu: got %h want 000000ab", rd); end
      tests++; if (rd_cnt + wb_cnt != t0) begin fails++; $display("FAIL sb_traffic: got %0d want 0", rd_cnt + wb_cnt - t0); end
   endtask
   task automatic test_half_store();
      op(1, 32'h46, 32'h1234BEEF, 3'b001, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      op(0, 32'h46, 0, 3'b001, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'hFFFFBEEF) begin fails++; $display("FAIL sh_lh: got %h want ffffbeef", rd); end
      op(0, 32'h46, 0, 3'b101, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL sh_lhu: got %h want 0000beef", rd); end
      op(0, 32'h44, 0, 3'b010, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (rd !== 32'hBEEF7788) begin fails++; $display("FAIL sh_lw: got %h want beef7788", rd); end
   endtask
   task automatic test_dirty_evict();
      op(0, 32'hC0, 0, 3'b010, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (dwb != 1 || wb_addr !== 28'h4) begin fails++; $display("FAIL evict_wb: count %0d addr %h want 1 / 4", dwb, wb_addr); end
      tests++; if (wb_data[63:0] !== 64'hBEEF7788_11AB3344) begin fails++; $display("FAIL evict_wb_data: got %h want beef778811ab3344", wb_data[63:0]); end
      tests++; if (drd != 1 || rd_addr !== 28'hC || wb_t >= rd_t) begin fails++; $display("FAIL evict_fetch: count %0d addr %h order %0t/%0t want 1 / c after wb", drd, rd_addr, wb_t, rd_t); end
      tests++; if (cyc != 14) begin fails++; $display("FAIL evict_latency: got %0d want 14", cyc); end
      tests++; if (rd !== init_word(32'h30)) begin fails++; $display("FAIL evict_data: got %h want %h", rd, init_word(32'h30)); end
   endtask
   task automatic test_reset_alloc();
      @(negedge clk);
      read_en = 1'b1; address = 32'h40; func3 = 3'b010;
      repeat (3) @(negedge clk);
      tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rst_alloc_pre: mem_read %b want 1", mem_read); end
      #2 reset = 1'b1;
      #1;
      tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || busywait !== 1'b0) begin
         fails++; $display("FAIL rst_alloc_drop: rd %b wr %b busy %b want 0 0 0", mem_read, mem_write, busywait);
      end
      #1 reset = 1'b0; read_en = 1'b0;
      mv = '0; md = '0;
      op(0, 32'h40, 0, 3'b010, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
      tests++; if (drd != 1 || cyc != 8) begin fails++; $display("FAIL rst_alloc_remiss: reads %0d cycles %0d want 1 / 8", drd, cyc); end
      tests++; if (rd !== 32'h11AB3344) begin fails++; $display("FAIL rst_alloc_data: got %h want 11ab3344", rd); end
   endtask
   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         bit wr;
         logic [31:0] a, d;
         logic [2:0] f;
         lat = $urandom_range(0, 3);
         wr = 1'($urandom_range(0, 1));
         a = $urandom & 32'h3FF;
         d = $urandom;
         f = 3'($urandom_range(0, 7));
         op(wr, a, d, f, rd, cyc, erd, ecyc, drd, dwb, edrd, edwb);
         tests++; if (rd !== erd) begin fails++; $display("FAIL rand_data: op %0d addr %h f3 %0d got %h want %h", n, a, f, rd, erd); end
         tests++; if (cyc != ecyc) begin fails++; $display("FAIL rand_latency: op %0d addr %h got %0d want %0d", n, a, cyc, ecyc); end
         tests++; if (drd != edrd || dwb != edwb) begin fails++; $display("FAIL rand_traffic: op %0d reads %0d wbs %0d want %0d %0d", n, drd, dwb, edrd, edwb); end
         if (dwb == 1) begin
            tests++; if (wb_data !== ref_blk(wb_addr)) begin fails++; $display("FAIL rand_wb_data: blk %h got %h want %h", wb_addr, wb_data, ref_blk(wb_addr)); end
         end
      end
      tests++; if (both_cnt != 0) begin fails++; $display("FAIL rd_wr_overlap: got %0d want 0", both_cnt); end
   endtask
   task automatic test_wide();
      @(negedge clk);
      read_en_w = 1'b1; address_w = 32'h1E4; cyc = 0;
      #1;
      tests++; if (busywait_w !== 1'b1) begin fails++; $display("FAIL wide_stall: got %b want 1", busywait_w); end
      while (busywait_w && cyc < 50) begin
         @(negedge clk); #1; cyc++;
      end
      tests++; if (busywait_w !== 1'b0) begin fails++; $display("FAIL wide_timeout: busywait %b want 0", busywait_w); end
      tests++; if (w_addr !== 27'hF) begin fails++; $display("FAIL wide_addr: got %h want 00000f", w_addr); end
      tests++; if (read_data_w !== init_word(32'h79)) begin fails++; $display("FAIL wide_data: got %h want %h", read_data_w, init_word(32'h79)); end
      @(negedge clk);
      read_en_w = 1'b0;
   endtask
   initial begin
      test_reset();
      test_clean_miss();
      test_byte_store();
      test_half_store();
      test_dirty_evict();
      test_reset_alloc();
      test_random();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Parametrised write-back, write-allocate, direct-mapped data cache controller for the RV32IM pipeline MEM stage. It holds the tag/valid/dirty/data arrays and runs the miss-handling FSM against the block-wide data memory. It performs byte-lane-correct load extraction and store merging for all RV32 load/store FUNC3 codes. It replaces the fixed-geometry controller with configurable set count and block size, and sub-word stores that modify only the addressed lanes.

## Interface
- SETS, 8: number of cache lines; power of two, ≥2.
- BLOCK_WORDS, 4: 32-bit words per line; power of two, ≥1.
- Derived widths:
  - OFF_W = log2(BLOCK_WORDS)+2
  - IDX_W = log2(SETS)
  - TAG_W = 32-IDX_W-OFF_W
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READ_EN  in  1  load request.
- WRITE_EN  in  1  store request; wins if both enables are high.
- ADDRESS  in  32  byte address (ALU result).
- WRITEDATA  in  32  store data from rs2.
- FUNC3  in  3  load/store width code.
- READ_DATA  out  32  extended load result.
- BUSYWAIT  out  1  stall to the pipeline.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  32-OFF_W  block address.
- MEM_WRITEDATA  out  32*BLOCK_WORDS  victim block.
- MEM_READDATA  in  32*BLOCK_WORDS  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

## Operation
- Address split:
  - tag = ADDRESS[31:IDX_W+OFF_W]
  - index = ADDRESS[IDX_W+OFF_W-1:OFF_W]
  - word select = ADDRESS[OFF_W-1:2]
  - lane = ADDRESS[1:0]
- Hit: request active, valid[index], and tag match.
- Loads (lane from ADDRESS[1:0]; halfword lane from ADDRESS[1]):
  - 000 LB: sign-extend the addressed byte.
  - 001 LH: sign-extend the addressed halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the addressed byte.
  - 101 LHU: zero-extend the addressed halfword.
  - 011/110/111: treated as LW.
  - Misaligned low bits are ignored; access is aligned down to the natural boundary.
- Stores write only the addressed lanes; other bytes of the word are preserved:
  - 000 SB: 1 byte.
  - 001 SH: 2 bytes.
  - Others: full word.
  - A store hit sets dirty[index].
- FSM states:
  - IDLE: on a miss, go to WRITEBACK if the line is valid and dirty, otherwise ALLOCATE.
  - WRITEBACK:
    - MEM_WRITE=1.
    - MEM_ADDRESS = {old tag, index}.
    - MEM_WRITEDATA = line.
    - On the first edge with MEM_BUSYWAIT=0, go to ALLOCATE.
  - ALLOCATE:
    - MEM_READ=1.
    - MEM_ADDRESS = {tag, index}.
    - On the first edge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
  - UPDATE: write the line, set valid=1, dirty=0, write the tag, then go to IDLE. The retried access then hits.
- MEM_READ and MEM_WRITE are never high together. MEM_ADDRESS and MEM_WRITEDATA are held stable while either is high.
- Reset clears valid/dirty for all lines and sets the FSM to IDLE. The data and tag arrays are not cleared.

## Timing
- Reset values:
  - BUSYWAIT=0
  - MEM_READ=0
  - MEM_WRITE=0
  - MEM_ADDRESS=0
  - READ_DATA=0
  - FSM=IDLE
- Read hit:
  - READ_DATA is valid combinationally in the request cycle.
  - BUSYWAIT stays 0.
  - READ_DATA=0 when there is no read hit.
- Write hit: BUSYWAIT=0; the array is updated at the rising edge ending the request cycle.
- Miss:
  - BUSYWAIT rises combinationally in the request cycle.
  - BUSYWAIT stays high through WRITEBACK, ALLOCATE and UPDATE.
  - BUSYWAIT falls in the IDLE cycle where the access hits.
- Clean-miss latency: 1 (ALLOCATE entry) + memory cycles + 1 (UPDATE) + hit cycle.
- Dirty miss: adds the write-back duration.
- The request inputs must be held stable by the pipeline while BUSYWAIT=1.
- RESET during WRITEBACK or ALLOCATE:
  - MEM_READ, MEM_WRITE and BUSYWAIT drop asynchronously.
  - No partial line is written.

## Structure
- Package dcache_pkg holds:
  - FUNC3 load/store encodings.
  - FSM state enum {IDLE, WRITEBACK, ALLOCATE, UPDATE}.
  - Width-derivation functions.
- Sub-module dcache_lane_align (combinational) handles load extract/extend and store byte-enable merge.
- dcache_ctrl holds the arrays and the FSM.

## Test plan
- Clean miss:
  - Stimulus: after reset, LW 0x40; memory returns words {0x11223344, 0x55667788, …} after 5 cycles.
  - Response: MEM_READ=1 with MEM_ADDRESS=0x0000004; BUSYWAIT high until the hit cycle; READ_DATA=0x11223344.
- Byte store:
  - Stimulus: line from scenario 1 resident; SB 0xAB to 0x42; then LW 0x40, LB 0x42, LBU 0x42.
  - Response: 0x11AB3344, 0xFFFFFFAB, 0x000000AB respectively; no memory traffic.
- Halfword store:
  - Stimulus: SH 0xBEEF to 0x46; then LH 0x46 and LHU 0x46.
  - Response: LH=0xFFFFBEEF; LHU=0x0000BEEF; bytes 0x44–0x45 unchanged (0x7788).
- Dirty eviction:
  - Stimulus: after scenario 2, LW 0xC0 (same index 4).
  - Response: MEM_WRITE with MEM_ADDRESS=0x0000004 and the block containing 0x11AB3344; then MEM_READ with MEM_ADDRESS=0x000000C.
- Reset during ALLOCATE:
  - Stimulus: RESET pulses mid-fetch, then LW 0x40.
  - Response: MEM_READ and BUSYWAIT drop immediately; the next LW 0x40 misses again.
- Wide geometry:
  - Stimulus: SETS=16, BLOCK_WORDS=8; LW 0x1E4.
  - Response: MEM_ADDRESS=0x000000F (27 bits); READ_DATA = word 1 of the fetched block.
